// File: rtl/hdmi_pkg.sv
// Shared types for the HDMI stream output path: lock state machine states,
// a video timing record with the 640x480 defaults, and a counter width helper.
package hdmi_pkg;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } timing_t;

  localparam timing_t VGA_640X480 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
  };

  // Counter width for a count of 'total' positions, never narrower than 1 bit.
  function automatic int cnt_w(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/hdmi_timing_core.sv
// Free-running horizontal/vertical slot counters with sync and active-area
// decode of the current position. Counters only ever restart on reset.
module hdmi_timing_core
  import hdmi_pkg::*;
#(
  parameter int PPC      = 2,
  parameter int H_ACTIVE = VGA_640X480.h_active,
  parameter int H_FP     = VGA_640X480.h_fp,
  parameter int H_SYNC   = VGA_640X480.h_sync,
  parameter int H_BP     = VGA_640X480.h_bp,
  parameter int V_ACTIVE = VGA_640X480.v_active,
  parameter int V_FP     = VGA_640X480.v_fp,
  parameter int V_SYNC   = VGA_640X480.v_sync,
  parameter int V_BP     = VGA_640X480.v_bp,
  parameter int HW       = cnt_w((H_ACTIVE + H_FP + H_SYNC + H_BP) / PPC),
  parameter int VW       = cnt_w(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk24,
  input  logic          rst_n,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          active,
  output logic          hs,
  output logic          vs
);

  localparam int HT     = (H_ACTIVE + H_FP + H_SYNC + H_BP) / PPC;
  localparam int VT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_ACT  = H_ACTIVE / PPC;
  localparam int HS_BEG = (H_ACTIVE + H_FP) / PPC;
  localparam int HS_END = (H_ACTIVE + H_FP + H_SYNC) / PPC;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = V_ACTIVE + V_FP + V_SYNC;

  always_ff @(posedge clk24) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (int'(h) == HT - 1) begin
      h <= '0;
      v <= (int'(v) == VT - 1) ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  // Compare in int so end-of-range bounds equal to the total still decode.
  assign active = (int'(h) < H_ACT) && (int'(v) < V_ACTIVE);
  assign hs     = (int'(h) >= HS_BEG) && (int'(h) < HS_END);
  assign vs     = (int'(v) >= VS_BEG) && (int'(v) < VS_END);

endmodule

// File: rtl/hdmi_stream_out.sv
// Locks an incoming pixel-beat stream to a free-running video raster and
// emits registered HDMI pixel/sync/blank signals; faults drop back to SEEK.
module hdmi_stream_out
  import hdmi_pkg::*;
#(
  parameter int   PPC      = 2,
  parameter int   BPC      = 8,
  parameter int   H_ACTIVE = VGA_640X480.h_active,
  parameter int   H_FP     = VGA_640X480.h_fp,
  parameter int   H_SYNC   = VGA_640X480.h_sync,
  parameter int   H_BP     = VGA_640X480.h_bp,
  parameter int   V_ACTIVE = VGA_640X480.v_active,
  parameter int   V_FP     = VGA_640X480.v_fp,
  parameter int   V_SYNC   = VGA_640X480.v_sync,
  parameter int   V_BP     = VGA_640X480.v_bp,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic                   clk24,
  input  logic                   rst_n,
  input  logic [PPC*3*BPC-1:0]   s_data,
  input  logic                   s_valid,
  input  logic                   s_sof,
  input  logic                   s_eol,
  output logic                   s_ready,
  output logic [PPC*3*BPC-1:0]   hdmi_data,
  output logic                   hdmi_hsync,
  output logic                   hdmi_vsync,
  output logic                   hdmi_hblank,
  output logic                   hdmi_vblank,
  output logic                   hdmi_active_video,
  output logic                   locked,
  output logic                   underflow,
  output state_t                 dbg_state
);

  localparam int HW    = cnt_w((H_ACTIVE + H_FP + H_SYNC + H_BP) / PPC);
  localparam int VW    = cnt_w(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int H_ACT = H_ACTIVE / PPC;

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          active, hs, vs;
  logic          at_origin, eol_slot, fire, fault;
  state_t        state, state_nxt;

  hdmi_timing_core #(
    .PPC(PPC), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk24 (clk24),
    .rst_n (rst_n),
    .h     (h),
    .v     (v),
    .active(active),
    .hs    (hs),
    .vs    (vs)
  );

  assign at_origin = (h == '0) && (v == '0);
  assign eol_slot  = (int'(h) == H_ACT - 1);
  assign dbg_state = state;

  // Handshake: a beat transfers on any clk24 edge where s_valid && s_ready.
  // In SEEK, ready drops for a valid SOF beat so that beat is left in place
  // for ARMED to take at the frame origin.
  always_comb begin
    s_ready   = 1'b0;
    state_nxt = state;
    fault     = 1'b0;
    if (rst_n) begin
      case (state)
        SEEK: begin
          s_ready = !(s_valid && s_sof);
          if (s_valid && s_sof) state_nxt = ARMED;
        end
        ARMED: begin
          s_ready = at_origin;
          if (at_origin && s_valid) state_nxt = LOCKED;
        end
        LOCKED: begin
          s_ready = active;
          if (active) begin
            fault = !s_valid || (s_eol != eol_slot) || (s_sof && !at_origin);
            if (fault) state_nxt = SEEK;
          end
        end
        default: state_nxt = SEEK;
      endcase
    end
  end

  assign fire = s_valid && s_ready;

  always_ff @(posedge clk24) begin
    if (!rst_n) state <= SEEK;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk24) begin
    if (!rst_n) begin
      hdmi_data         <= '0;
      hdmi_hsync        <= ~HS_POL;
      hdmi_vsync        <= ~VS_POL;
      hdmi_hblank       <= 1'b1;
      hdmi_vblank       <= 1'b1;
      hdmi_active_video <= 1'b0;
      locked            <= 1'b0;
      underflow         <= 1'b0;
    end else begin
      // Beats taken in SEEK are discarded; everything else consumed is shown.
      hdmi_data         <= (fire && state != SEEK) ? s_data : '0;
      hdmi_hsync        <= hs ? HS_POL : ~HS_POL;
      hdmi_vsync        <= vs ? VS_POL : ~VS_POL;
      hdmi_hblank       <= (int'(h) >= H_ACT);
      hdmi_vblank       <= (int'(v) >= V_ACTIVE);
      hdmi_active_video <= active;
      locked            <= (state_nxt == LOCKED);
      if (fault) underflow <= 1'b1;
    end
  end

endmodule
